// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state qualification FSM.
// Every output is a flop loaded from next-state decodes, so there is no combinational path from raw_in.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic push,
   output logic press_pulse,
   output logic release_pulse,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s1_d, s2_q, s2_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_q, push_d;
   logic             press_pulse_q, press_pulse_d;
   logic             release_pulse_q, release_pulse_d;
   logic             busy_q, busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q            <= 1'b0;
         s2_q            <= 1'b0;
         state_q         <= IDLE;
         cnt_q           <= '0;
         push_q          <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         s1_q            <= s1_d;
         s2_q            <= s2_d;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         push_q          <= push_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         busy_q          <= busy_d;
      end
   end

   always_comb begin
      s1_d    = raw_in;
      s2_d    = s1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (s2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!s2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (s2_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs register the decode of the state being entered, so they line up with state_q.
      push_d          = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      busy_d          = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
      press_pulse_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
      release_pulse_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
   end

   assign push          = push_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4; edge numbers count from the
// first rising edge that samples a newly driven raw_in level.
module tb_button_debouncer;

   logic clk = 1'b0;
   logic rst;
   logic raw_in;
   logic push, press_pulse, release_pulse, busy;

   int errors = 0;
   int checks = 0;

   button_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .raw_in        (raw_in),
      .push          (push),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   int n_press, n_rel, n_push, n_both, n_busy;

   initial begin
      rst    = 1'b1;
      raw_in = 1'b0;
      repeat (3) tick();
      chk("reset_push", push, 0);
      chk("reset_press", press_pulse, 0);
      chk("reset_release", release_pulse, 0);
      chk("reset_busy", busy, 0);
      rst = 1'b0;
      repeat (3) tick();

      // Clean press
      raw_in = 1'b1;
      tick(); tick();
      chk("press_e2_busy", busy, 0);
      tick();
      chk("press_e3_busy", busy, 1);
      tick(); tick(); tick();
      chk("press_e6_busy", busy, 1);
      chk("press_e6_push", push, 0);
      chk("press_e6_pulse", press_pulse, 0);
      tick();
      chk("press_e7_push", push, 1);
      chk("press_e7_pulse", press_pulse, 1);
      chk("press_e7_busy", busy, 0);
      tick();
      chk("press_e8_pulse", press_pulse, 0);
      chk("press_e8_push", push, 1);

      // Release
      raw_in = 1'b0;
      n_press = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         n_press += press_pulse;
         if (i == 3) chk("rel_e3_busy", busy, 1);
      end
      chk("rel_e6_push", push, 1);
      chk("rel_e6_pulse", release_pulse, 0);
      tick();
      chk("rel_e7_push", push, 0);
      chk("rel_e7_pulse", release_pulse, 1);
      chk("rel_e7_busy", busy, 0);
      tick();
      chk("rel_e8_pulse", release_pulse, 0);
      chk("rel_no_press", n_press, 0);

      // Glitch: two high samples, then low
      raw_in = 1'b1;
      tick();
      tick();
      raw_in = 1'b0;
      chk("glitch_e2_busy", busy, 0);
      n_press = 0; n_push = 0; n_busy = 0;
      for (int i = 3; i <= 12; i++) begin
         tick();
         n_press += press_pulse;
         n_push  += push;
         n_busy  += busy;
      end
      chk("glitch_press", n_press, 0);
      chk("glitch_push", n_push, 0);
      chk("glitch_busy_cycles", n_busy, 2);
      chk("glitch_busy_end", busy, 0);

      // Bounce 1,0,1,0,1 then held high; last rising sample is edge 5
      n_press = 0;
      for (int i = 1; i <= 20; i++) begin
         raw_in = (i % 2 == 1 || i > 5) ? 1'b1 : 1'b0;
         tick();
         n_press += press_pulse;
         if (i == 10) chk("bounce_e10_push", push, 0);
         if (i == 11) begin
            chk("bounce_e11_push", push, 1);
            chk("bounce_e11_pulse", press_pulse, 1);
         end
      end
      chk("bounce_press_count", n_press, 1);

      // Asynchronous reset mid-cycle while pushed
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_push", push, 0);
      chk("rst_async_release", release_pulse, 0);
      chk("rst_async_busy", busy, 0);
      tick(); tick();
      rst = 1'b0;
      n_rel = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_rel += release_pulse;
         if (i == 6) chk("rst_e6_push", push, 0);
         if (i == 7) begin
            chk("rst_e7_pulse", press_pulse, 1);
            chk("rst_e7_push", push, 1);
         end
      end
      chk("rst_no_release", n_rel, 0);

      // Long hold from a clean idle
      raw_in = 1'b0;
      repeat (12) tick();
      chk("long_start_push", push, 0);
      raw_in = 1'b1;
      n_press = 0; n_rel = 0; n_push = 0; n_both = 0; n_busy = 0;
      for (int i = 1; i <= 1000; i++) begin
         tick();
         n_press += press_pulse;
         n_rel   += release_pulse;
         n_both  += (press_pulse & release_pulse);
         if (i >= 7) begin
            n_push += (push == 1'b0);
            n_busy += busy;
         end
      end
      chk("long_press_count", n_press, 1);
      chk("long_release_count", n_rel, 0);
      chk("long_push_drops", n_push, 0);
      chk("long_busy_after", n_busy, 0);
      chk("long_both_pulses", n_both, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
